// File: rtl/dm_dma_copy.sv
`default_nettype none
// ============================================================================
//  Module   : dm_dma_copy
//  Purpose  : Bus initiator on the DM port that copies a block of 32-bit
//             words from a source region to a destination region, one
//             read / wait / write sequence per word, ascending addresses.
//  Option   : `define DMA_CHECKSUM_EN to accumulate a running sum of the
//             copied words on the checksum output (tied to 0 otherwise).
//  Revision : 1.0  initial release
// ============================================================================
module dm_dma_copy #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 10,
  parameter int READ_LATENCY = 1    // legal range 1..3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [DATA_WIDTH-1:0]  checksum,
  output logic                   DM_enable,
  output logic                   DM_read,
  output logic                   DM_write,
  output logic [ADDR_WIDTH-1:0]  DM_address,
  output logic [DATA_WIDTH-1:0]  DM_in,
  input  logic [DATA_WIDTH-1:0]  DM_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  // Latency counter only needs to hold 1..3.
  localparam logic [1:0] c_read_lat = 2'(READ_LATENCY);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_src;
  logic [ADDR_WIDTH-1:0]  r_dst;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [1:0]             r_lat;
  logic                   r_error;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_capture;
  logic                   w_misaligned;

  assign w_misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign error        = r_error;

  // State register; reset aborts any copy in progress.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and bus/status outputs, all idle-low by default.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_capture   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    DM_enable   = 1'b0;
    DM_read     = 1'b0;
    DM_write    = 1'b0;
    DM_address  = '0;
    DM_in       = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_misaligned) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = (word_count == '0) ? S_FIN : S_RD;
          end
        end
      end
      S_RD: begin
        busy        = 1'b1;
        DM_enable   = 1'b1;
        DM_read     = 1'b1;
        DM_address  = r_src;
        w_state_nxt = S_WT;
      end
      S_WT: begin
        busy = 1'b1;
        // Read data is valid in the last wait cycle.
        if (r_lat == 2'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        busy        = 1'b1;
        DM_enable   = 1'b1;
        DM_write    = 1'b1;
        DM_address  = r_dst;
        DM_in       = r_data;
        w_state_nxt = (r_remaining == COUNT_WIDTH'(1)) ? S_FIN : S_RD;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address/count/data datapath; addresses wrap modulo 2^ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_lat       <= '0;
      r_error     <= 1'b0;
    end else begin
      r_error <= w_reject;
      if (w_accept) begin
        r_src       <= src_addr;
        r_dst       <= dst_addr;
        r_remaining <= word_count;
      end
      if (r_state == S_RD)      r_lat <= c_read_lat;
      else if (r_state == S_WT) r_lat <= r_lat - 2'd1;
      if (w_capture) r_data <= DM_out;
      if (r_state == S_WR) begin
        r_src       <= r_src + ADDR_WIDTH'(4);
        r_dst       <= r_dst + ADDR_WIDTH'(4);
        r_remaining <= r_remaining - COUNT_WIDTH'(1);
      end
    end
  end

`ifdef DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Running sum of captured words, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (rst)            r_checksum <= '0;
    else if (w_accept)  r_checksum <= '0;
    else if (w_capture) r_checksum <= r_checksum + DM_out;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_dma_copy.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_dma_copy
//  Purpose  : Scoreboard bench for dm_dma_copy. Two instances (read latency
//             1 and 3) each own a DM responder model; a reference copy of
//             memory predicts every read address and write, and a monitor
//             pops and compares them as the DUT presents bus accesses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_dma_copy;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i   [2];
  logic        start_i [2];
  logic [11:0] src_i   [2];
  logic [11:0] dst_i   [2];
  logic [9:0]  cnt_i   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic [31:0] cks_o   [2];
  logic        en_o    [2];
  logic        rd_o    [2];
  logic        wr_o    [2];
  logic [11:0] addr_o  [2];
  logic [31:0] din_o   [2];
  logic [31:0] rp      [2][3];

  logic [31:0] mem     [2][1024];
  logic [31:0] ref_mem [2][1024];
  logic        init_req = 1'b0;

  logic [11:0] exp_rd[$];
  wr_t         exp_wr[$];
  int          n_done [2];
  int          n_err  [2];
  int          n_vec = 0;
  int          n_bad = 0;

  dm_dma_copy #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst_i[0]), .start(start_i[0]),
    .src_addr(src_i[0]), .dst_addr(dst_i[0]), .word_count(cnt_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .error(err_o[0]), .checksum(cks_o[0]),
    .DM_enable(en_o[0]), .DM_read(rd_o[0]), .DM_write(wr_o[0]),
    .DM_address(addr_o[0]), .DM_in(din_o[0]), .DM_out(rp[0][0])
  );

  dm_dma_copy #(.READ_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst_i[1]), .start(start_i[1]),
    .src_addr(src_i[1]), .dst_addr(dst_i[1]), .word_count(cnt_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .error(err_o[1]), .checksum(cks_o[1]),
    .DM_enable(en_o[1]), .DM_read(rd_o[1]), .DM_write(wr_o[1]),
    .DM_address(addr_o[1]), .DM_in(din_o[1]), .DM_out(rp[1][2])
  );

  // DM responder: word-addressed array, read data delayed through a pipe.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (init_req) begin
        for (int w = 0; w < 1024; w++) mem[i][w] <= ref_mem[i][w];
      end else if (en_o[i] && wr_o[i]) begin
        mem[i][addr_o[i][11:2]] <= din_o[i];
      end
      rp[i][0] <= (en_o[i] && rd_o[i]) ? mem[i][addr_o[i][11:2]] : $urandom;
      rp[i][1] <= rp[i][0];
      rp[i][2] <= rp[i][1];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: pops predicted accesses when the DUT drives the bus.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [11:0] ea;
      wr_t         ew;
      if (en_o[i] && rd_o[i]) begin
        if (exp_rd.size() == 0) begin
          check($sformatf("i%0d_unexpected_read", i), 64'(addr_o[i]), 64'hFFFF_FFFF);
        end else begin
          ea = exp_rd.pop_front();
          check($sformatf("i%0d_rd_addr", i), 64'(addr_o[i]), 64'(ea));
        end
      end
      if (en_o[i] && wr_o[i]) begin
        if (exp_wr.size() == 0) begin
          check($sformatf("i%0d_unexpected_write", i), 64'(addr_o[i]), 64'hFFFF_FFFF);
        end else begin
          ew = exp_wr.pop_front();
          check($sformatf("i%0d_wr_addr", i), 64'(addr_o[i]), 64'(ew.a));
          check($sformatf("i%0d_wr_data", i), 64'(din_o[i]), 64'(ew.d));
        end
      end
      if (rd_o[i] && wr_o[i])
        check($sformatf("i%0d_rd_and_wr", i), 64'(1), 64'(0));
      if (en_o[i] != (rd_o[i] || wr_o[i]))
        check($sformatf("i%0d_enable_strobe", i), 64'(en_o[i]), 64'(rd_o[i] || wr_o[i]));
      if (!en_o[i] && addr_o[i] != 12'h000)
        check($sformatf("i%0d_idle_addr", i), 64'(addr_o[i]), 64'(0));
      if (!(en_o[i] && wr_o[i]) && din_o[i] != 32'h0)
        check($sformatf("i%0d_idle_din", i), 64'(din_o[i]), 64'(0));
      if (done_o[i]) n_done[i]++;
      if (err_o[i])  n_err[i]++;
    end
  end

  // Reference model: plain sequential word copy over the model memory.
  task automatic model_copy(input int i, input logic [11:0] s, input logic [11:0] d,
                            input int n, output logic [31:0] sum);
    logic [11:0] sa, da;
    logic [31:0] w;
    wr_t         e;
    sum = 32'h0;
    for (int k = 0; k < n; k++) begin
      sa = s + 12'(4 * k);
      da = d + 12'(4 * k);
      w  = ref_mem[i][sa[11:2]];
      exp_rd.push_back(sa);
      e.a = da;
      e.d = w;
      exp_wr.push_back(e);
      ref_mem[i][da[11:2]] = w;
      sum = sum + w;
    end
  endtask

  task automatic sync_mem();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  task automatic outputs_zero(input int i, input string tag);
    check($sformatf("i%0d_%s_ctrl", i, tag),
          64'({busy_o[i], done_o[i], err_o[i], en_o[i], rd_o[i], wr_o[i]}), 64'(0));
    check($sformatf("i%0d_%s_addr", i, tag), 64'(addr_o[i]), 64'(0));
    check($sformatf("i%0d_%s_din", i, tag), 64'(din_o[i]), 64'(0));
    check($sformatf("i%0d_%s_cks", i, tag), 64'(cks_o[i]), 64'(0));
  endtask

  // One start request on instance i; spur = cycle to pulse a stray start,
  // rst_cyc = cycle in which reset is raised (0 = none).
  task automatic run_copy(input int i, input logic [11:0] s, input logic [11:0] d,
                          input int n, input int spur, input int rst_cyc);
    int          lat, exp_cyc, win, wrote, done_cyc, err_cyc, nbusy, nd0, ne0, nmem;
    logic        bad;
    logic [31:0] sum;
    lat     = (i == 0) ? 1 : 3;
    bad     = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    exp_cyc = n * (2 + lat) + 1;
    wrote   = bad ? 0 : ((rst_cyc > 0) ? rst_cyc / (2 + lat) : n);
    model_copy(i, s, d, wrote, sum);
    win      = bad ? 6 : exp_cyc + 6;
    done_cyc = 0;
    err_cyc  = 0;
    nbusy    = 0;
    nd0      = n_done[i];
    ne0      = n_err[i];
    @(negedge clk);
    start_i[i] = 1'b1;
    src_i[i]   = s;
    dst_i[i]   = d;
    cnt_i[i]   = 10'(n);
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      start_i[i] = 1'b0;
      rst_i[i]   = 1'b0;
      if (done_o[i] && done_cyc == 0) done_cyc = c;
      if (err_o[i] && err_cyc == 0)   err_cyc  = c;
      if (busy_o[i]) nbusy++;
      if (rst_cyc > 0 && c == rst_cyc + 1) outputs_zero(i, "after_rst");
      if (c == spur) begin
        start_i[i] = 1'b1;
        src_i[i]   = {10'($urandom), 2'b00};
        dst_i[i]   = {10'($urandom), 2'b00};
        cnt_i[i]   = 10'($urandom_range(1, 5));
      end
      if (c == rst_cyc) rst_i[i] = 1'b1;
    end
    start_i[i] = 1'b0;
    if (bad) begin
      check($sformatf("i%0d_error_cycle", i), 64'(err_cyc), 64'(1));
      check($sformatf("i%0d_error_pulses", i), 64'(n_err[i] - ne0), 64'(1));
      check($sformatf("i%0d_busy_cycles", i), 64'(nbusy), 64'(0));
      check($sformatf("i%0d_done_pulses", i), 64'(n_done[i] - nd0), 64'(0));
    end else if (rst_cyc > 0) begin
      check($sformatf("i%0d_done_pulses", i), 64'(n_done[i] - nd0), 64'(0));
      check($sformatf("i%0d_busy_cycles", i), 64'(nbusy), 64'(rst_cyc));
    end else begin
      check($sformatf("i%0d_done_cycle", i), 64'(done_cyc), 64'(exp_cyc));
      check($sformatf("i%0d_done_pulses", i), 64'(n_done[i] - nd0), 64'(1));
      check($sformatf("i%0d_busy_cycles", i), 64'(nbusy), 64'(n * (2 + lat)));
      check($sformatf("i%0d_error_pulses", i), 64'(n_err[i] - ne0), 64'(0));
`ifdef DMA_CHECKSUM_EN
      check($sformatf("i%0d_checksum", i), 64'(cks_o[i]), 64'(sum));
`endif
    end
    check($sformatf("i%0d_reads_left", i), 64'(exp_rd.size()), 64'(0));
    check($sformatf("i%0d_writes_left", i), 64'(exp_wr.size()), 64'(0));
    exp_rd.delete();
    exp_wr.delete();
    nmem = 0;
    for (int w = 0; w < 1024; w++) if (mem[i][w] !== ref_mem[i][w]) nmem++;
    check($sformatf("i%0d_mem_image", i), 64'(nmem), 64'(0));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          i, n, r, spur, ecyc;
    logic [11:0] s, d;
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b1; start_i[k] = 1'b0;
      src_i[k] = '0; dst_i[k] = '0; cnt_i[k] = '0;
      n_done[k] = 0; n_err[k] = 0;
      for (int w = 0; w < 1024; w++) ref_mem[k][w] = $urandom;
    end
    ref_mem[0][0] = 32'd5;
    ref_mem[0][1] = 32'd7;
    ref_mem[0][2] = 32'd9;
    ref_mem[0][3] = 32'hFFFF_FFFF;
    sync_mem();
    repeat (3) @(negedge clk);
    outputs_zero(0, "reset");
    outputs_zero(1, "reset");
    rst_i[0] = 1'b0;
    rst_i[1] = 1'b0;
    repeat (2) @(negedge clk);

    run_copy(0, 12'h000, 12'h100, 4, 0, 0);   // preload block, checksum 20
    run_copy(0, 12'h200, 12'h300, 0, 0, 0);   // zero count
    run_copy(0, 12'h002, 12'h100, 3, 0, 0);   // misaligned source
    run_copy(0, 12'h010, 12'h101, 3, 0, 0);   // misaligned destination
    run_copy(0, 12'hFF8, 12'h040, 3, 0, 0);   // source wraps past 0xFFC
    run_copy(0, 12'h080, 12'h180, 4, 2, 6);   // stray start, reset in WR of word 2
    run_copy(1, 12'h020, 12'h400, 2, 0, 0);   // latency 3
    run_copy(1, 12'h000, 12'h000, 0, 1, 0);   // start in FIN ignored

    for (int t = 0; t < 24; t++) begin
      i = int'($urandom_range(0, 1));
      s = {10'($urandom), 2'b00};
      d = {10'($urandom), 2'b00};
      n = int'($urandom_range(1, 10));
      r = int'($urandom_range(0, 9));
      if (r == 0) n = 0;
      else if (r == 1) begin
        if ($urandom_range(0, 1) == 0) s[0] = 1'b1;
        else d[1] = 1'b1;
      end else if (r == 2) d = s + 12'(4 * $urandom_range(1, 3));
      ecyc = n * ((i == 0) ? 3 : 5) + 1;
      spur = (r == 1 || $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, ecyc));
      run_copy(i, s, d, n, spur, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_dma_copy.md
Name: dm_dma_copy

Overview:
- Bus initiator on the data-memory port (DM_read/DM_write/DM_enable/DM_address/DM_in/DM_out) that copies a block of 32-bit words from one DM region to another.
- Drives the dm responder the same way the core does: byte addresses, word-aligned.
- Used to preload or relocate data and to stress dm without running a program.
- Sits beside top; a simple arbiter (outside this block) selects which initiator owns the DM port.

Parameters:
- ADDR_WIDTH, 12, width of the DM byte address.
- DATA_WIDTH, 32, width of a DM word.
- COUNT_WIDTH, 10, width of the word-count input.
- READ_LATENCY, 1, cycles from a read request to valid DM_out; legal range 1..3.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  source byte address; bits [1:0] must be 0.
- dst_addr  in  ADDR_WIDTH  destination byte address; bits [1:0] must be 0.
- word_count  in  COUNT_WIDTH  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a copy completes.
- error  out  1  one-cycle pulse when a start is rejected.
- checksum  out  DATA_WIDTH  sum of copied words (optional feature only).
- DM_enable  out  1  DM access strobe.
- DM_read  out  1  read request.
- DM_write  out  1  write request.
- DM_address  out  ADDR_WIDTH  byte address of the current access.
- DM_in  out  DATA_WIDTH  write data to DM.
- DM_out  in  DATA_WIDTH  read data from DM.

Behaviour:
- Reset: all outputs are 0; state is IDLE; internal address, count, data and latency registers are cleared.
- Reset mid-copy aborts the copy immediately. No done pulse is produced and there is no further DM access.

State machine (IDLE, RD, WT, WR, FIN):
- IDLE: on start=1, latch src_addr, dst_addr and word_count.
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0, pulse error for the next cycle and stay in IDLE (busy stays 0).
  - Else if word_count==0, go to FIN with no DM access.
  - Else go to RD; busy=1.
- RD, one cycle:
  - DM_enable=1, DM_read=1, DM_write=0, DM_address=current src.
  - Go to WT with the latency counter set to READ_LATENCY.
- WT:
  - DM_enable=DM_read=DM_write=0.
  - Decrement the latency counter each cycle.
  - In the cycle the counter reaches 1, capture DM_out into the data register and go to WR.
  - WT therefore lasts READ_LATENCY cycles.
- WR, one cycle:
  - DM_enable=1, DM_write=1, DM_read=0, DM_address=current dst, DM_in=captured word.
  - Then src+=4, dst+=4, remaining-=1.
  - If remaining becomes 0, go to FIN; else go to RD.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Timing: per-word cost is 2+READ_LATENCY cycles, so 3 cycles at the default. A copy of N words takes N*(2+READ_LATENCY)+1 cycles from the start edge to the done pulse.
- DM_read and DM_write are never high together. DM_enable is high only in RD and WR.
- DM_in is 0 outside WR.
- DM_address is 0 outside RD and WR.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFC+4 wraps to 0x000 silently.
- Regions are copied in ascending order with no overlap protection. If dst is above src and the regions overlap, source data is overwritten as the copy proceeds.
- start while busy is ignored, with no error pulse.
- start in the FIN cycle is ignored.

Optional Feature:
- Macro: DMA_CHECKSUM_EN.
- Defined:
  - checksum clears to 0 on each accepted start.
  - It adds each captured word, modulo 2^DATA_WIDTH, in the WT capture cycle.
  - It holds its value after done until the next accepted start.
- Undefined: checksum is tied to 0 and no adder is synthesised.

Test Plan:
- Preload DM[0..12] bytes with 5,7,9,0xFFFFFFFF; start src=0 dst=0x100 count=4 → DM[0x100..0x10C]=5,7,9,0xFFFFFFFF; done pulses 13 cycles after start; 4 read and 4 write strobes; checksum=20 with DMA_CHECKSUM_EN.
- Start with count=0 → no DM_enable; done pulses in the cycle after start; busy never asserts.
- Start with src=0x002 → error pulse in the next cycle; no DM access; busy and done stay 0.
- Start src=0xFF8 dst=0x040 count=3 → reads at 0xFF8, 0xFFC, 0x000 (wrap); writes at 0x040, 0x044, 0x048.
- Assert a second start mid-copy, then assert rst during the WR of word 2 of a count=4 copy → second start has no effect; after rst all outputs are 0, only word 1 (plus word 2 if the write edge preceded rst) landed, and no done pulse.
- READ_LATENCY=3, count=2 → WT lasts 3 cycles; done 11 cycles after start; data copied correctly.
